sdpram_be_sc: RTL and testbench

Parametrised single-clock simple dual-port RAM: one write port with byte enables, one read port, optional output register and selectable read-during-write collision mode. Contains an init sequencer that clears every entry to INIT_VALUE after reset or on request. It is the generic successor of the fixed-size byte-enable SDP RAM IPs, for buffers and tables inside the SoC shell.

---
 rtl/sdpram_be_sc_if.sv | 33 +++
 rtl/sdpram_be_sc.sv | 131 +++++++++++++
 tb/tb_sdpram_be_sc.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdpram_be_sc_if.sv
// Port bundle for sdpram_be_sc: init control, byte-enable write port, read port
// and the FSM state for observation.
interface sdpram_be_sc_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = 8
);
  // Handshake: wr_en/rd_en/init_req are single-cycle strobes that are accepted
  // only when init_busy is low (init_busy acts as an inverted ready). Strobes
  // that arrive while init_busy is high are dropped, not queued. rd_valid
  // pulses for exactly one cycle per accepted read, in issue order.
  logic                  init_req;
  logic                  init_busy;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BE_WIDTH-1:0]   wr_byte_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  dbg_state;

  modport master (
    output init_req, wr_en, wr_addr, wr_data, wr_byte_en, rd_en, rd_addr,
    input  init_busy, rd_data, rd_valid, dbg_state
  );

  modport slave (
    input  init_req, wr_en, wr_addr, wr_data, wr_byte_en, rd_en, rd_addr,
    output init_busy, rd_data, rd_valid, dbg_state
  );
endinterface

// File: rtl/sdpram_be_sc.sv
// Single-clock simple dual-port RAM with byte enables, optional output register,
// selectable collision mode and an init sweep that clears every entry.
module sdpram_be_sc #(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    BYTE_SIZE  = 8,
  parameter int                    BE_WIDTH   = DATA_WIDTH / BYTE_SIZE,
  parameter int                    OUTPUT_REG = 0,
  parameter int                    BYPASS     = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  sdpram_be_sc_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  generate
    if ((DATA_WIDTH % BYTE_SIZE) != 0 || BE_WIDTH != DATA_WIDTH / BYTE_SIZE ||
        (BYTE_SIZE != 8 && BYTE_SIZE != 9)) begin : g_bad_cfg
      $error("sdpram_be_sc: DATA_WIDTH must be a multiple of BYTE_SIZE (8 or 9)");
    end
  endgenerate

  typedef enum logic {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  init_busy_q;
  logic                  wr_go;
  logic                  rd_go;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd1_data;
  logic                  rd1_valid;

  // The counter parks at DEPTH-1 so a finished sweep never starts a second pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      init_cnt    <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          if (&init_cnt) begin
            state       <= ST_IDLE;
            init_busy_q <= 1'b0;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.init_req) begin
            state       <= ST_INIT;
            init_cnt    <= '0;
            init_busy_q <= 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign bus.init_busy = init_busy_q;
  assign bus.dbg_state = state;

  assign wr_go = (state == ST_IDLE) && bus.wr_en;
  assign rd_go = (state == ST_IDLE) && bus.rd_en;

  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[init_cnt] <= INIT_VALUE;
    end else if (wr_go) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (bus.wr_byte_en[i]) begin
          mem[bus.wr_addr][i*BYTE_SIZE +: BYTE_SIZE] <= bus.wr_data[i*BYTE_SIZE +: BYTE_SIZE];
        end
      end
    end
  end

  // Write-first collision merges the incoming lanes over the stored word.
  always_comb begin
    rd_word = mem[bus.rd_addr];
    if (BYPASS != 0 && wr_go && bus.wr_addr == bus.rd_addr) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (bus.wr_byte_en[i]) begin
          rd_word[i*BYTE_SIZE +: BYTE_SIZE] = bus.wr_data[i*BYTE_SIZE +: BYTE_SIZE];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_valid <= 1'b0;
      rd1_data  <= '0;
    end else begin
      rd1_valid <= rd_go;
      if (rd_go) begin
        rd1_data <= rd_word;
      end
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] rd2_data;
      logic                  rd2_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd2_valid <= 1'b0;
          rd2_data  <= '0;
        end else begin
          rd2_valid <= rd1_valid;
          if (rd1_valid) begin
            rd2_data <= rd1_data;
          end
        end
      end

      assign bus.rd_data  = rd2_data;
      assign bus.rd_valid = rd2_valid;
    end else begin : g_no_out_reg
      assign bus.rd_data  = rd1_data;
      assign bus.rd_valid = rd1_valid;
    end
  endgenerate
endmodule

// File: tb/tb_sdpram_be_sc.sv
// Bench for sdpram_be_sc: three instances (write-first, read-first, registered
// output) share one stimulus stream and are checked against a reference memory.
module tb_sdpram_be_sc;
  localparam int AW    = 6;
  localparam int DW    = 64;
  localparam int BEW   = 8;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           init_req = 1'b0;
  logic           wr_en    = 1'b0;
  logic [AW-1:0]  wr_addr  = '0;
  logic [DW-1:0]  wr_data  = '0;
  logic [BEW-1:0] wr_be    = '0;
  logic           rd_en    = 1'b0;
  logic [AW-1:0]  rd_addr  = '0;

  sdpram_be_sc_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BEW)) if_a ();
  sdpram_be_sc_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BEW)) if_b ();
  sdpram_be_sc_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BEW)) if_c ();

  assign if_a.init_req = init_req;  assign if_b.init_req = init_req;  assign if_c.init_req = init_req;
  assign if_a.wr_en = wr_en;        assign if_b.wr_en = wr_en;        assign if_c.wr_en = wr_en;
  assign if_a.wr_addr = wr_addr;    assign if_b.wr_addr = wr_addr;    assign if_c.wr_addr = wr_addr;
  assign if_a.wr_data = wr_data;    assign if_b.wr_data = wr_data;    assign if_c.wr_data = wr_data;
  assign if_a.wr_byte_en = wr_be;   assign if_b.wr_byte_en = wr_be;   assign if_c.wr_byte_en = wr_be;
  assign if_a.rd_en = rd_en;        assign if_b.rd_en = rd_en;        assign if_c.rd_en = rd_en;
  assign if_a.rd_addr = rd_addr;    assign if_b.rd_addr = rd_addr;    assign if_c.rd_addr = rd_addr;

  sdpram_be_sc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a)
  );
  sdpram_be_sc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b)
  );
  sdpram_be_sc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state: memory image and remaining init-sweep cycles.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_left = 0;

  logic [DW-1:0] exp_a[$], exp_b[$], exp_c[$];
  int            due_a[$], due_b[$], due_c[$];
  logic [DW-1:0] last_a = '0, last_b = '0, last_c = '0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (if_a.rd_valid === 1'b1) begin
        if (exp_a.size() == 0) check("a_spurious_valid", DW'(1), DW'(0));
        else begin
          check("a_rd_data", if_a.rd_data, exp_a[0]);
          check("a_latency", DW'(cyc), DW'(due_a[0]));
          last_a = exp_a.pop_front();
          void'(due_a.pop_front());
        end
      end else check("a_hold", if_a.rd_data, last_a);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (if_b.rd_valid === 1'b1) begin
        if (exp_b.size() == 0) check("b_spurious_valid", DW'(1), DW'(0));
        else begin
          check("b_rd_data", if_b.rd_data, exp_b[0]);
          check("b_latency", DW'(cyc), DW'(due_b[0]));
          last_b = exp_b.pop_front();
          void'(due_b.pop_front());
        end
      end else check("b_hold", if_b.rd_data, last_b);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (if_c.rd_valid === 1'b1) begin
        if (exp_c.size() == 0) check("c_spurious_valid", DW'(1), DW'(0));
        else begin
          check("c_rd_data", if_c.rd_data, exp_c[0]);
          check("c_latency", DW'(cyc), DW'(due_c[0]));
          last_c = exp_c.pop_front();
          void'(due_c.pop_front());
        end
      end else check("c_hold", if_c.rd_data, last_c);
    end
  end

  // One clock cycle: called at a falling edge, returns at the next one.
  task automatic step(input logic ir, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic [BEW-1:0] be,
                      input logic re, input logic [AW-1:0] ra);
    logic [DW-1:0] old_w, byp_w;
    check("a_init_busy", DW'(if_a.init_busy), DW'(m_left != 0));
    check("b_init_busy", DW'(if_b.init_busy), DW'(m_left != 0));
    check("c_init_busy", DW'(if_c.init_busy), DW'(m_left != 0));
    init_req = ir; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra;
    if (m_left == 0) begin
      if (re) begin
        old_w = m_mem[ra];
        byp_w = old_w;
        for (int i = 0; i < BEW; i++)
          if (we && be[i] && wa == ra) byp_w[i*8 +: 8] = wd[i*8 +: 8];
        exp_a.push_back(byp_w); due_a.push_back(cyc + 1);
        exp_b.push_back(old_w); due_b.push_back(cyc + 1);
        exp_c.push_back(byp_w); due_c.push_back(cyc + 2);
      end
      if (we)
        for (int i = 0; i < BEW; i++)
          if (be[i]) m_mem[wa][i*8 +: 8] = wd[i*8 +: 8];
      if (ir) m_left = DEPTH;
    end else begin
      m_mem[AW'(DEPTH - m_left)] = '0;
      m_left--;
    end
    @(negedge clk);
    init_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BEW-1:0] be);
    step(1'b0, 1'b1, a, d, be, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, a);
  endtask

  // Asserts reset mid-cycle (away from any edge) and checks the async values.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    init_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    #1;
    check("a_rst_valid", DW'(if_a.rd_valid), DW'(0));
    check("a_rst_data", if_a.rd_data, DW'(0));
    check("a_rst_busy", DW'(if_a.init_busy), DW'(1));
    check("a_rst_state", DW'(if_a.dbg_state), DW'(0));
    check("b_rst_valid", DW'(if_b.rd_valid), DW'(0));
    check("b_rst_data", if_b.rd_data, DW'(0));
    check("c_rst_valid", DW'(if_c.rd_valid), DW'(0));
    check("c_rst_data", if_c.rd_data, DW'(0));
    check("c_rst_busy", DW'(if_c.init_busy), DW'(1));
    exp_a.delete(); exp_b.delete(); exp_c.delete();
    due_a.delete(); due_b.delete(); due_c.delete();
    last_a = '0; last_b = '0; last_c = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_left = DEPTH;
  endtask

  task automatic count_busy(input string tag);
    int n = 0;
    while (if_a.init_busy === 1'b1 && n < 200) begin
      idle(1);
      n++;
    end
    check(tag, DW'(n), DW'(DEPTH));
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    count_busy("busy_after_reset");

    for (int a = 0; a < DEPTH; a++) rd(AW'(a));
    idle(3);

    wr(6'd5, 64'h1122334455667788, 8'hFF);
    wr(6'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    rd(6'd5);
    idle(3);

    step(1'b0, 1'b1, 6'd3, '1, 8'h01, 1'b1, 6'd3);
    rd(6'd3);
    idle(3);

    for (int i = 0; i < 4; i++) wr(AW'(i), DW'(10 + i), 8'hFF);
    for (int i = 0; i < 4; i++) rd(AW'(i));
    idle(4);

    repeat (300)
      step(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), {$urandom(), $urandom()},
           BEW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
    idle(3);

    for (int a = 0; a < DEPTH; a++) wr(AW'(a), {$urandom(), $urandom()}, 8'hFF);
    rd(6'd62);
    step(1'b1, 1'b0, '0, '0, '0, 1'b1, 6'd63);
    for (int k = 0; k < DEPTH; k++)
      step(k == 20, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), {$urandom(), $urandom()},
           8'hFF, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)));
    for (int a = 0; a < DEPTH; a++) rd(AW'(a));
    idle(3);

    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    idle(30);
    do_reset();
    count_busy("busy_after_midinit_reset");

    wr(6'd7, 64'h0123456789ABCDEF, 8'hFF);
    rd(6'd7);
    do_reset();
    count_busy("busy_after_midread_reset");
    for (int i = 0; i < 4; i++) rd(AW'(i + 6));
    idle(4);

    check("a_queue_empty", DW'(exp_a.size()), DW'(0));
    check("b_queue_empty", DW'(exp_b.size()), DW'(0));
    check("c_queue_empty", DW'(exp_c.size()), DW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
